d_hazard_scoreboard: RTL and testbench
======================================

// Module: d_hazard_scoreboard
// PURPOSE
//  Read-side companion of the D-stage register file in the 5-stage pipeline.
//  Tracks destination registers of in-flight E/M/W instructions with Tnew countdowns.
//  Compares them against D-stage Tuse demands; raises stall, or selects forwarding sources for D/E/M operands.
//  W-stage writes into the register file are already bypassed inside the file.
//  D-stage sources therefore never forward from W.
// PARAMETERS
//  AW      5   register address width (32 GPRs, $0 hard-wired zero)
//  TW      2   width of Tuse/Tnew fields (values 0..3)
// PORTS
//  clk          in   1   pipeline clock, rising edge
//  reset        in   1   synchronous, active-high; clears all tracked entries
//  D_rs         in   AW  D-stage source 1 address (register-file A1)
//  D_rt         in   AW  D-stage source 2 address (register-file A2)
//  D_rs_tuse    in   TW  cycles after D until rs value needed (3 = unused)
//  D_rt_tuse    in   TW  cycles after D until rt value needed (3 = unused)
//  D_dst        in   AW  D-stage destination (0 = no write)
//  D_tnew       in   TW  cycles after E until result exists (jal 0, ALU 1, load 2)
//  stall        out  1   freeze PC and F/D reg, bubble into E
//  D_fwd_rs     out  2   D rs source: 0 GRF, 1 E result, 2 M result
//  D_fwd_rt     out  2   D rt source: same encoding
//  E_fwd_rs     out  2   E rs source: 0 pipeline reg, 1 M result, 2 W result
//  E_fwd_rt     out  2   E rt source: same encoding
//  M_fwd_rt     out  1   M store-data source: 0 pipeline reg, 1 W result
// BEHAVIOUR
//  State:
//   - E entry {rs, rt, dst, tnew}; M entry {rt, dst, tnew}; W entry {dst}.
//   - All entries are registered.
//  Reset (sync, reset=1 at posedge):
//   - All rs/rt/dst fields become 0; all tnew fields become 0.
//   - All outputs are then 0, because dst 0 never matches and sources 0 never stall.
//   - Reset mid-stall drops the stalled hazard; the bubble is not retained.
//  Every posedge with reset=0:
//   - W.dst <= M.dst.
//   - M <= E, with M.tnew = (E.tnew==0) ? 0 : E.tnew-1 (saturating).
//   - stall=0: E <= {D_rs, D_rt, D_dst, D_tnew}.
//   - stall=1: E <= bubble {0,0,0,0}; M/W still advance.
//  Stall (combinational, same cycle):
//   - stall = hz(D_rs, D_rs_tuse) | hz(D_rt, D_rt_tuse).
//   - hz(r, u) = r!=0 & ((E.dst==r & E.tnew>u) | (M.dst==r & M.tnew>u)).
//   - Tuse 3 never stalls, because Tnew <= 2.
//  D forwarding, nearest stage wins:
//   - If E.dst==r (r!=0): sel = (E.tnew==0) ? 1 : 0.
//     A not-ready E match yields 0, never an older M value; the value forwards later.
//   - Else if M.dst==r and M.tnew==0: sel = 2.
//   - Else: sel = 0.
//  E forwarding:
//   - If M.dst==r (r!=0) and M.tnew==0: sel = 1.
//   - Else if W.dst==r (r!=0): sel = 2.
//   - Else: sel = 0.
//   - A not-ready M match blocks W selection.
//  M forwarding:
//   - M_fwd_rt = (M.rt!=0 & W.dst==M.rt).
//  Invariants:
//   - Register 0 is never a hazard or forward target, even if an entry has dst 0.
//   - D rs and rt are evaluated independently; both may forward from different stages in one cycle.
//   - All outputs are combinational from registered state and D inputs; no output is registered.
//   - Latency: a D instruction affects E-compare one cycle after issue (when not stalled).
// TESTING
//  1. lw $8 (tnew 2) then add $9,$8,$8 (tuse 1).
//     -> 1 stall cycle; next cycle stall=0.
//     -> add in E with lw in W: E_fwd_rs=E_fwd_rt=2.
//  2. addu $8 (tnew 1) then beq $8,$0 (tuse 0).
//     -> stall=1 for 1 cycle.
//     -> then D_fwd_rs=2 (from M); D_fwd_rt=0.
//  3. addu $8 then sw $8,0($0) (rt tuse 2).
//     -> no stall; D_fwd_rt=0.
//     -> E_fwd_rt=1; M_fwd_rt=0.
//  4. addu $0 (dst 0, tnew 1) then beq $0 (tuse 0).
//     -> stall=0, D_fwd_rs=0.
//  5. jal (dst 31, tnew 0) then jr $31 (tuse 0).
//     -> stall=0, D_fwd_rs=1.
//  6. Assert reset while case 1 is stalled.
//     -> next cycle all outputs 0; no residual stall.

Source files
------------

// File: rtl/d_hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks E/M/W destinations with Tnew countdowns and
// resolves Tuse demands into a stall or per-operand forwarding selects.
module d_hazard_scoreboard #(
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic [TW-1:0] D_rs_tuse,
  input  logic [TW-1:0] D_rt_tuse,
  input  logic [AW-1:0] D_dst,
  input  logic [TW-1:0] D_tnew,
  output logic          stall,
  output logic [1:0]    D_fwd_rs,
  output logic [1:0]    D_fwd_rt,
  output logic [1:0]    E_fwd_rs,
  output logic [1:0]    E_fwd_rt,
  output logic          M_fwd_rt
);

  logic [AW-1:0] e_rs_q, e_rt_q, e_dst_q;
  logic [TW-1:0] e_tnew_q;
  logic [AW-1:0] m_rt_q, m_dst_q;
  logic [TW-1:0] m_tnew_q;
  logic [AW-1:0] w_dst_q;

  function automatic logic hz(input logic [AW-1:0] r, input logic [TW-1:0] u);
    return (r != '0) && (((e_dst_q == r) && (e_tnew_q > u)) ||
                         ((m_dst_q == r) && (m_tnew_q > u)));
  endfunction

  // A not-ready E match must not fall back to an older M value.
  function automatic logic [1:0] d_sel(input logic [AW-1:0] r);
    if ((r != '0) && (e_dst_q == r)) return (e_tnew_q == '0) ? 2'd1 : 2'd0;
    else if ((r != '0) && (m_dst_q == r) && (m_tnew_q == '0)) return 2'd2;
    else return 2'd0;
  endfunction

  // A not-ready M match blocks selection of the older W value.
  function automatic logic [1:0] e_sel(input logic [AW-1:0] r);
    if ((r != '0) && (m_dst_q == r)) return (m_tnew_q == '0) ? 2'd1 : 2'd0;
    else if ((r != '0) && (w_dst_q == r)) return 2'd2;
    else return 2'd0;
  endfunction

  always_comb begin
    stall    = hz(D_rs, D_rs_tuse) | hz(D_rt, D_rt_tuse);
    D_fwd_rs = d_sel(D_rs);
    D_fwd_rt = d_sel(D_rt);
    E_fwd_rs = e_sel(e_rs_q);
    E_fwd_rt = e_sel(e_rt_q);
    M_fwd_rt = (m_rt_q != '0) && (w_dst_q == m_rt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_rt_q   <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
    end else begin
      w_dst_q  <= m_dst_q;
      m_rt_q   <= e_rt_q;
      m_dst_q  <= e_dst_q;
      m_tnew_q <= (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
      if (stall) begin
        e_rs_q   <= '0;
        e_rt_q   <= '0;
        e_dst_q  <= '0;
        e_tnew_q <= '0;
      end else begin
        e_rs_q   <= D_rs;
        e_rt_q   <= D_rt;
        e_dst_q  <= D_dst;
        e_tnew_q <= D_tnew;
      end
    end
  end

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Cycle-by-cycle vector table for the hazard scoreboard; expected outputs are
// queued when each vector is driven and checked at the following falling edge.
module tb_d_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew;
  logic       stall;
  logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic       M_fwd_rt;

  always #5 clk = ~clk;

  d_hazard_scoreboard #(.AW(5), .TW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_rs_tuse (D_rs_tuse),
    .D_rt_tuse (D_rt_tuse),
    .D_dst     (D_dst),
    .D_tnew    (D_tnew),
    .stall     (stall),
    .D_fwd_rs  (D_fwd_rs),
    .D_fwd_rt  (D_fwd_rt),
    .E_fwd_rs  (E_fwd_rs),
    .E_fwd_rt  (E_fwd_rt),
    .M_fwd_rt  (M_fwd_rt)
  );

  typedef struct {
    string nm;
    bit    rst;
    int    rs, rsu, rt, rtu, dst, tn;
    int    st, dfs, dft, efs, eft, mft;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic v(input string nm, input bit rst, input int rs, rsu, rt, rtu, dst, tn,
                   input int st, dfs, dft, efs, eft, mft);
    vec_t x;
    x.nm = nm; x.rst = rst;
    x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu; x.dst = dst; x.tn = tn;
    x.st = st; x.dfs = dfs; x.dft = dft; x.efs = efs; x.eft = eft; x.mft = mft;
    tbl.push_back(x);
  endtask

  // Bubble-like instruction in D: no sources used, no destination.
  task automatic n(input string nm, input int efs, eft, mft);
    v(nm, 1'b0, 0, 3, 0, 3, 0, 0, 0, 0, 0, efs, eft, mft);
  endtask

  task automatic chk(input string nm, input string fld, input logic [1:0] act, input int ex);
    logic [1:0] e;
    e = 2'(ex);
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s.%s: got %b, expected %b", nm, fld, act, e);
    end
  endtask

  initial begin
    // Case 0: reset state
    n("reset_state", 0, 0, 0);
    // Case 1: lw $8 then add $9,$8,$8
    v("c1_lw",        0, 29, 1, 0, 3, 8, 2,  0, 0, 0, 0, 0, 0);
    v("c1_add_stall", 0, 8, 1, 8, 1, 9, 1,   1, 0, 0, 0, 0, 0);
    v("c1_add_go",    0, 8, 1, 8, 1, 9, 1,   0, 0, 0, 0, 0, 0);
    n("c1_add_in_e", 2, 2, 0);
    n("c1_f1", 0, 0, 0); n("c1_f2", 0, 0, 0); n("c1_f3", 0, 0, 0);
    // Case 2: addu $8 then beq $8,$0
    v("c2_addu",      0, 1, 1, 2, 1, 8, 1,   0, 0, 0, 0, 0, 0);
    v("c2_beq_stall", 0, 8, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    v("c2_beq_go",    0, 8, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0);
    n("c2_beq_w_fwd", 2, 0, 0); n("c2_f2", 0, 0, 0); n("c2_f3", 0, 0, 0);
    // Case 3: addu $8 then sw $8,0($0)
    v("c3_addu", 0, 1, 1, 2, 1, 8, 1,   0, 0, 0, 0, 0, 0);
    v("c3_sw",   0, 0, 1, 8, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    n("c3_sw_in_e", 0, 1, 0);
    n("c3_sw_in_m", 0, 0, 1);
    n("c3_f1", 0, 0, 0); n("c3_f2", 0, 0, 0);
    // Case 4: writes to $0 never hazard
    v("c4_addu0", 0, 1, 1, 2, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    v("c4_beq0",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    n("c4_f1", 0, 0, 0); n("c4_f2", 0, 0, 0); n("c4_f3", 0, 0, 0);
    // Case 5: jal then jr $31
    v("c5_jal", 0, 0, 3, 0, 3, 31, 0,   0, 0, 0, 0, 0, 0);
    v("c5_jr",  0, 31, 0, 0, 3, 0, 0,   0, 1, 0, 0, 0, 0);
    n("c5_jr_in_e", 1, 0, 0); n("c5_f2", 0, 0, 0); n("c5_f3", 0, 0, 0);
    // Case 7: rs from M and rt from E in the same cycle
    v("c7_a8",  0, 1, 1, 2, 1, 8, 1,   0, 0, 0, 0, 0, 0);
    v("c7_b9",  0, 0, 3, 0, 3, 9, 0,   0, 0, 0, 0, 0, 0);
    v("c7_use", 0, 8, 0, 9, 0, 0, 0,   0, 2, 1, 0, 0, 0);
    n("c7_use_in_e", 2, 1, 0);
    n("c7_use_in_m", 0, 0, 1);
    n("c7_f3", 0, 0, 0);
    // Case 8: not-ready M match hides the W copy
    v("c8_lwa", 0, 29, 1, 0, 3, 8, 2,  0, 0, 0, 0, 0, 0);
    v("c8_lwb", 0, 29, 1, 0, 3, 8, 2,  0, 0, 0, 0, 0, 0);
    v("c8_use", 0, 8, 3, 0, 3, 0, 0,   0, 0, 0, 0, 0, 0);
    n("c8_blocked", 0, 0, 0); n("c8_f2", 0, 0, 0); n("c8_f3", 0, 0, 0);
    // Case 6: reset while stalled
    v("c6_lw",        0, 29, 1, 0, 3, 8, 2,  0, 0, 0, 0, 0, 0);
    v("c6_stall_rst", 1, 8, 1, 8, 1, 9, 1,   1, 0, 0, 0, 0, 0);
    v("c6_after_rst", 0, 8, 1, 8, 1, 9, 1,   0, 0, 0, 0, 0, 0);
    n("c6_add_in_e", 0, 0, 0);
    n("c6_f2", 0, 0, 0);

    reset = 1'b1;
    D_rs = '0; D_rt = '0; D_dst = '0;
    D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_tnew = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      vec_t x;
      vec_t e;
      @(posedge clk);
      #1;
      x = tbl[i];
      reset     = x.rst;
      D_rs      = 5'(x.rs);
      D_rs_tuse = 2'(x.rsu);
      D_rt      = 5'(x.rt);
      D_rt_tuse = 2'(x.rtu);
      D_dst     = 5'(x.dst);
      D_tnew    = 2'(x.tn);
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      chk(e.nm, "stall",    {1'b0, stall},    e.st);
      chk(e.nm, "D_fwd_rs", D_fwd_rs,         e.dfs);
      chk(e.nm, "D_fwd_rt", D_fwd_rt,         e.dft);
      chk(e.nm, "E_fwd_rs", E_fwd_rs,         e.efs);
      chk(e.nm, "E_fwd_rt", E_fwd_rt,         e.eft);
      chk(e.nm, "M_fwd_rt", {1'b0, M_fwd_rt}, e.mft);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
